// File: rtl/ex_div_stall_unit.sv
// EX-stage multi-cycle DIV/DIVU engine (radix-2 restoring, one quotient bit per cycle).
// Requests an EX stall while busy and holds the finished result until EX advances.
module ex_div_stall_unit #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STALL_W      = 6,
    parameter int unsigned EX_STALL_BIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  div_en,
    input  logic                  div_signed,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   div_result,
    output logic                  div_ready,
    output logic                  stallreq_for_ex
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      rem_q, rem_d;
    logic [DATA_W-1:0]      quo_q, quo_d;
    logic [DATA_W-1:0]      dvs_q, dvs_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]    res_q, res_d;

    logic [DATA_W:0]        rem_sh;
    logic [DATA_W:0]        trial;
    logic [DATA_W-1:0]      rem_nx, quo_nx;
    logic [DATA_W-1:0]      op1_abs, op2_abs;
    logic                   unused_stall;

    // Only the EX freeze bit matters here; the other stall bits are don't-care.
    assign unused_stall = ^stall;

    assign div_result = res_q;
    assign div_ready  = (state_q == DONE);

    assign op1_abs = (div_signed && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    assign op2_abs = (div_signed && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

    // One restoring step: remainder is kept below the divisor, so DATA_W bits store it
    // and the extra trial bit is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (trial[DATA_W]) begin
            rem_nx = rem_sh[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b0};
        end else begin
            rem_nx = trial[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        quo_d           = quo_q;
        dvs_d           = dvs_q;
        neg_quo_d       = neg_quo_q;
        neg_rem_d       = neg_rem_q;
        res_d           = res_q;
        stallreq_for_ex = 1'b0;

        if (annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    stallreq_for_ex = div_en;
                    if (div_en) begin
                        if (opdata2 == '0) begin
                            state_d = DIV_ZERO;
                        end else begin
                            rem_d     = '0;
                            quo_d     = op1_abs;
                            dvs_d     = op2_abs;
                            neg_quo_d = div_signed & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            neg_rem_d = div_signed & opdata1[DATA_W-1];
                            cnt_d     = '0;
                            state_d   = DIV_ON;
                        end
                    end
                end
                DIV_ZERO: begin
                    stallreq_for_ex = 1'b1;
                    res_d           = '0;
                    state_d         = DONE;
                end
                DIV_ON: begin
                    stallreq_for_ex = 1'b1;
                    rem_d           = rem_nx;
                    quo_d           = quo_nx;
                    cnt_d           = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        res_d   = {(neg_rem_q ? -rem_nx : rem_nx),
                                   (neg_quo_q ? -quo_nx : quo_nx)};
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!stall[EX_STALL_BIT]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
